ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data width on every data port.
REQ-002 Parameter ADDR_W, default 10, RAM address width; DEPTH = 2**ADDR_W (1024).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset); synchronous deassert is the system's responsibility.
REQ-005 s_valid  in  1  upstream write request.
REQ-006 s_ready  out  1  controller can accept s_data this cycle.
REQ-007 s_data  in  DATA_W  upstream write data.
REQ-008 m_valid  out  1  m_data holds a valid entry.
REQ-009 m_ready  in  1  downstream accepts m_data.
REQ-010 m_data  out  DATA_W  oldest unread entry.
REQ-011 wena  out  1  RAM port-A write enable.
REQ-012 addra  out  ADDR_W  RAM port-A address.
REQ-013 dina  out  DATA_W  RAM port-A write data.
REQ-014 renb  out  1  RAM port-B read enable.
REQ-015 addrb  out  ADDR_W  RAM port-B address.
REQ-016 doutb  in  DATA_W  RAM port-B read data.
REQ-017 dvalb  in  1  doutb valid; asserted by the RAM exactly 1 cycle after renb.
REQ-018 count  out  ADDR_W+1  entries accepted and not yet popped.
REQ-019 full, empty  out  1 each  count==DEPTH, count==0.

Function
REQ-020 Push = s_valid & s_ready; s_ready = !full (combinational).
REQ-021 On push: wena=1, addra=wr_ptr, dina=s_data in the same cycle (combinational); wr_ptr increments at the clock edge, modulo DEPTH.
REQ-022 ram_occ = entries written to the RAM and not yet read from it, range 0..DEPTH.
REQ-023 Output stage is a 2-entry FIFO (skid buffer); in_flight = number of issued reads whose dvalb is still pending (0 or 1).
REQ-024 renb=1, addrb=rd_ptr when ram_occ>0 and (buffered + in_flight) < 2 after accounting for a pop in the same cycle; rd_ptr increments modulo DEPTH on each renb.
REQ-025 A word written at edge t becomes readable at the earliest at cycle t+1 (ram_occ updates at edge t); same-cycle read/write of the same address never occurs.
REQ-026 dvalb=1 writes doutb into the output FIFO tail; dvalb with the output FIFO already full is a protocol error and never happens under REQ-024.
REQ-027 m_valid = output FIFO not empty; m_data = output FIFO head; pop = m_valid & m_ready.
REQ-028 count: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
REQ-029 When full, a push is refused even if a pop occurs in the same cycle (s_ready depends only on registered count).
REQ-030 Pointer wrap: rd_ptr/wr_ptr roll from DEPTH-1 to 0 with no gap or stall.
REQ-031 Latency: first word written into an empty controller appears on m_data with m_valid at cycle t+3 (edge t write, t+1 renb, t+2 dvalb edge, output registered).
REQ-032 Sustained throughput with m_ready=1 and s_valid=1: one word per cycle in and out.

Reset
REQ-033 rst=0 asynchronously clears wr_ptr, rd_ptr, ram_occ, in_flight, output FIFO and count; outputs become: s_ready=1, m_valid=0, m_data=0, wena=0, renb=0, addra=0, addrb=0, count=0, empty=1, full=0.
REQ-034 Reset mid-operation discards all stored and in-flight data; a dvalb arriving in the first cycle after reset release is ignored.
REQ-035 RAM contents are not cleared by reset.

Verification
REQ-036 Single word: push 32'h55 with m_ready=0 -> wena=1, addra=0 that cycle; m_valid=1, m_data=32'h55 three cycles later; count=1.
REQ-037 Overwrite order: push 32'h55 then 32'h22 -> popped in order 32'h55, 32'h22; count returns to 0, empty=1.
REQ-038 Fill: push 1024 words with m_ready=0 -> full=1, s_ready=0, count=1024; a 1025th s_valid is not accepted; after popping all, data 0..1023 in order.
REQ-039 Wrap/streaming: 3000 words with s_valid=1, m_ready=1 -> no stall after fill latency, pointers wrap twice, output sequence exact.
REQ-040 Backpressure: random m_ready toggling with continuous push -> no loss, no duplicate, renb never issued when buffered+in_flight would exceed 2.
REQ-041 Reset mid-stream: assert rst=0 with count=5 and a read in flight -> all outputs at reset values immediately; after release, next pushed word is the first word popped.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM (port A write, port B read,
// 1-cycle read latency) with a 2-entry output skid buffer for full throughput.
module ram_fifo_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              wena,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              renb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  input  logic              dvalb,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0]           wr_ptr, rd_ptr;
  logic [ADDR_W:0]             ram_occ;
  logic                        in_flight;
  logic [1:0][DATA_W-1:0]      obuf;
  logic                        ohead;
  logic [1:0]                  ocnt;
  logic                        push, pop, rd_go, fill;
  logic [2:0]                  pending;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign s_ready = !full;
  assign push    = s_valid & s_ready;
  assign m_valid = (ocnt != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = obuf[ohead];

  // Buffered words plus the one possibly in flight, after this cycle's pop;
  // a new read is only issued when its data is guaranteed a free slot.
  assign pending = 3'(ocnt) + 3'(in_flight) - 3'(pop);
  assign rd_go   = (ram_occ != '0) && (pending < 3'd2);

  // A dvalb not matched by an issued read (e.g. just after reset) is dropped.
  assign fill    = dvalb & in_flight;

  assign wena  = push;
  assign addra = wr_ptr;
  assign dina  = s_data;
  assign renb  = rd_go;
  assign addrb = rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_occ   <= '0;
      in_flight <= 1'b0;
      count     <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_go) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, rd_go})
        2'b10:   ram_occ <= ram_occ + (ADDR_W+1)'(1);
        2'b01:   ram_occ <= ram_occ - (ADDR_W+1)'(1);
        default: ram_occ <= ram_occ;
      endcase
      in_flight <= rd_go;
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Output skid buffer; ocnt is at most 1 whenever fill is set, so the tail
  // slot is simply head xor ocnt[0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      obuf  <= '0;
      ohead <= 1'b0;
      ocnt  <= 2'd0;
    end else begin
      if (fill) obuf[ohead ^ ocnt[0]] <= doutb;
      if (pop)  ohead <= ~ohead;
      ocnt <= ocnt + 2'(fill) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 1-cycle-latency RAM.
module tb_ram_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          wena;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          renb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic          dvalb;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_dout = '0;
  logic          ram_dval = 1'b0;
  logic          inj_dval = 1'b0;
  logic [DW-1:0] inj_data = '0;

  int checks = 0;
  int errors = 0;

  ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .wena(wena), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb), .dvalb(dvalb),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wena) ram[addra] <= dina;
    if (renb) ram_dout <= ram[addrb];
    ram_dval <= renb;
  end

  assign dvalb = ram_dval | inj_dval;
  assign doutb = inj_dval ? inj_data : ram_dout;

  task automatic test_reset;
    #2;
    checks++;
    if ({s_ready, m_valid, wena, renb, empty, full} !== 6'b100010)
      begin errors++; $display("FAIL reset_flags: got %b want 100010", {s_ready, m_valid, wena, renb, empty, full}); end
    checks++;
    if (m_data !== '0 || addra !== '0 || addrb !== '0 || count !== '0)
      begin errors++; $display("FAIL reset_values: got m_data=%h addra=%h addrb=%h count=%0d want all 0", m_data, addra, addrb, count); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b0; #1;
    checks++;
    if (wena !== 1'b1 || addra !== 10'd0 || dina !== 32'h55)
      begin errors++; $display("FAIL single_write: got wena=%b addra=%0d dina=%h want 1 0 00000055", wena, addra, dina); end
    @(negedge clk); s_valid = 1'b0; #1;
    checks++;
    if (count !== 11'd1 || renb !== 1'b1 || addrb !== 10'd0)
      begin errors++; $display("FAIL single_read_issue: got count=%0d renb=%b addrb=%0d want 1 1 0", count, renb, addrb); end
    @(negedge clk); #1;
    checks++;
    if (m_valid !== 1'b0)
      begin errors++; $display("FAIL single_early: got m_valid=%b want 0", m_valid); end
    @(negedge clk); #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h55)
      begin errors++; $display("FAIL single_latency: got m_valid=%b m_data=%h want 1 00000055", m_valid, m_data); end
    @(negedge clk);
  endtask

  task automatic test_order;
    s_valid = 1'b1; s_data = 32'h22; #1;
    checks++;
    if (addra !== 10'd1)
      begin errors++; $display("FAIL order_addra: got %0d want 1", addra); end
    @(negedge clk); s_valid = 1'b0;
    repeat (2) @(negedge clk);
    m_ready = 1'b1; #1;
    checks++;
    if (count !== 11'd2 || m_valid !== 1'b1 || m_data !== 32'h55)
      begin errors++; $display("FAIL order_first: got count=%0d m_valid=%b m_data=%h want 2 1 00000055", count, m_valid, m_data); end
    @(negedge clk); #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h22)
      begin errors++; $display("FAIL order_second: got m_valid=%b m_data=%h want 1 00000022", m_valid, m_data); end
    @(negedge clk); #1;
    checks++;
    if (m_valid !== 1'b0 || count !== 11'd0 || empty !== 1'b1)
      begin errors++; $display("FAIL order_drained: got m_valid=%b count=%0d empty=%b want 0 0 1", m_valid, count, empty); end
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill;
    int bad = 0;
    int exp = 1;
    int cyc = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      s_valid = 1'b1; s_data = DW'(i); #1;
      if (s_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0)
      begin errors++; $display("FAIL fill_accept: got %0d refused pushes want 0", bad); end
    s_data = 32'hBAD; #1;
    checks++;
    if (full !== 1'b1 || s_ready !== 1'b0 || count !== 11'd1024 || wena !== 1'b0)
      begin errors++; $display("FAIL fill_full: got full=%b s_ready=%b count=%0d wena=%b want 1 0 1024 0", full, s_ready, count, wena); end
    @(negedge clk); m_ready = 1'b1; #1;
    checks++;
    if (s_ready !== 1'b0 || wena !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'd0)
      begin errors++; $display("FAIL fill_pop_while_full: got s_ready=%b wena=%b m_valid=%b m_data=%h want 0 0 1 0", s_ready, wena, m_valid, m_data); end
    @(negedge clk); s_valid = 1'b0; #1;
    checks++;
    if (count !== 11'd1023)
      begin errors++; $display("FAIL fill_refused_count: got %0d want 1023", count); end
    while (exp < 1024 && cyc < 4000) begin
      if (m_valid === 1'b1) begin
        checks++;
        if (m_data !== DW'(exp))
          begin errors++; $display("FAIL fill_data: got %h want %h", m_data, DW'(exp)); end
        exp++;
      end
      @(negedge clk); #1; cyc++;
    end
    checks++;
    if (exp != 1024)
      begin errors++; $display("FAIL fill_drain_timeout: got %0d words want 1024", exp); end
    checks++;
    if (m_valid !== 1'b0 || count !== 11'd0 || empty !== 1'b1)
      begin errors++; $display("FAIL fill_empty: got m_valid=%b count=%0d empty=%b want 0 0 1", m_valid, count, empty); end
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream;
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    logic [DW-1:0] base = 32'hA000_0000;
    m_ready = 1'b1;
    while (popped < 3000 && cyc < 3200) begin
      s_valid = (pushed < 3000); s_data = base + DW'(pushed); #1;
      if (s_valid) begin
        checks++;
        if (s_ready !== 1'b1)
          begin errors++; $display("FAIL stream_in_stall: got s_ready=%b want 1 at word %0d", s_ready, pushed); end
        else pushed++;
      end
      if (m_valid === 1'b1) begin
        checks++;
        if (m_data !== base + DW'(popped))
          begin errors++; $display("FAIL stream_data: got %h want %h", m_data, base + DW'(popped)); end
        popped++;
      end else if (popped > 0) begin
        checks++; errors++;
        $display("FAIL stream_out_stall: got m_valid=0 want 1 after %0d words", popped);
      end
      @(negedge clk); cyc++;
    end
    s_valid = 1'b0;
    checks++;
    if (popped != 3000 || cyc != 3003)
      begin errors++; $display("FAIL stream_cycles: got %0d words in %0d cycles want 3000 in 3003", popped, cyc); end
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int pushed = 0;
    int popped = 0;
    int outst = 0;
    int cyc = 0;
    int rb;
    int pp;
    logic [DW-1:0] base = 32'hB000_0000;
    while (popped < 600 && cyc < 6000) begin
      s_valid = (pushed < 600); s_data = base + DW'(pushed);
      m_ready = 1'($urandom_range(0, 1)); #1;
      checks++;
      if (count !== 11'(pushed - popped))
        begin errors++; $display("FAIL bp_count: got %0d want %0d", count, pushed - popped); end
      if (s_valid && s_ready) pushed++;
      rb = int'(renb);
      pp = int'(m_valid && m_ready);
      checks++;
      if (outst + rb - pp > 2)
        begin errors++; $display("FAIL bp_read_overrun: got %0d outstanding want <= 2", outst + rb - pp); end
      if (pp != 0) begin
        checks++;
        if (m_data !== base + DW'(popped))
          begin errors++; $display("FAIL bp_data: got %h want %h", m_data, base + DW'(popped)); end
        popped++;
      end
      outst = outst + rb - pp;
      @(negedge clk); cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    checks++;
    if (popped != 600)
      begin errors++; $display("FAIL bp_timeout: got %0d words want 600", popped); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 32'hC0 + DW'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    s_valid = 1'b1; s_data = 32'hC5; m_ready = 1'b1; #1;
    checks++;
    if (renb !== 1'b1 || count !== 11'd5)
      begin errors++; $display("FAIL rmid_setup: got renb=%b count=%0d want 1 5", renb, count); end
    @(negedge clk); s_valid = 1'b0; m_ready = 1'b0; #1;
    checks++;
    if (count !== 11'd5 || dvalb !== 1'b1)
      begin errors++; $display("FAIL rmid_inflight: got count=%0d dvalb=%b want 5 1", count, dvalb); end
    rst = 1'b0; #1;
    checks++;
    if ({s_ready, m_valid, wena, renb, empty, full} !== 6'b100010 || m_data !== '0 ||
        addra !== '0 || addrb !== '0 || count !== '0)
      begin errors++; $display("FAIL rmid_reset: got flags=%b m_data=%h addra=%0d addrb=%0d count=%0d want 100010 0 0 0 0",
                               {s_ready, m_valid, wena, renb, empty, full}, m_data, addra, addrb, count); end
    @(negedge clk);
    rst = 1'b1;
    inj_dval = 1'b1; inj_data = 32'hDEAD;
    @(negedge clk);
    inj_dval = 1'b0; #1;
    checks++;
    if (m_valid !== 1'b0 || count !== 11'd0)
      begin errors++; $display("FAIL rmid_stale_dval: got m_valid=%b count=%0d want 0 0", m_valid, count); end
    s_valid = 1'b1; s_data = 32'h77; #1;
    checks++;
    if (addra !== 10'd0 || wena !== 1'b1)
      begin errors++; $display("FAIL rmid_wptr: got addra=%0d wena=%b want 0 1", addra, wena); end
    @(negedge clk); s_valid = 1'b0;
    repeat (2) @(negedge clk); #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h77)
      begin errors++; $display("FAIL rmid_first_word: got m_valid=%b m_data=%h want 1 00000077", m_valid, m_data); end
    m_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (m_valid !== 1'b0 || empty !== 1'b1)
      begin errors++; $display("FAIL rmid_drained: got m_valid=%b empty=%b want 0 1", m_valid, empty); end
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_order;
    test_fill;
    test_stream;
    test_backpressure;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before 1000000");
    $fatal(1);
  end

endmodule
